// File: rtl/racing_pkg.sv
// Shared types, default constants and start-position helpers for the racing game logic.
// Pure definitions; no timing of its own.
package racing_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CRASH = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  typedef logic [15:0] coord_t;

  localparam int DEF_N_ENEMY      = 3;
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_TRACK_LEFT   = 40;
  localparam int DEF_TRACK_RIGHT  = 600;
  localparam int DEF_CAR_W        = 8;
  localparam int DEF_STEP         = 4;
  localparam int DEF_SPEED_INIT   = 31;
  localparam int DEF_SPEED_CRASH  = 16;
  localparam int DEF_SPEED_MAX    = 250;
  localparam int DEF_LIVES        = 3;
  localparam int DEF_CRASH_FRAMES = 60;

  function automatic int xmin_of(int track_left);
    return track_left;
  endfunction

  // Rightmost enemy x keeps the whole sprite left of the shoulder.
  function automatic int xmax_of(int track_right, int car_w);
    return track_right - car_w;
  endfunction

  function automatic int enemy_x0(int i, int n, int xmin, int xmax);
    return xmin + ((i + 1) * (xmax - xmin)) / (n + 1);
  endfunction

  function automatic int enemy_y0(int i, int n, int v_active);
    return (i * v_active) / n;
  endfunction

endpackage

// File: rtl/racing_traffic_ctrl_enemy_lane.sv
// One enemy car: x/y/direction registers with vertical wrap and wall bounce.
// Updates one cycle after advance; passed is combinational for the current advance.
module enemy_lane
  import racing_pkg::*;
#(
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0,
  parameter bit DIR_INIT = 1'b0,
  parameter int XMIN     = 40,
  parameter int XMAX     = 592,
  parameter int V_ACTIVE = 480,
  parameter int STEP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reload,
  input  logic       advance,
  input  logic [3:0] dy,
  output coord_t     x,
  output coord_t     y,
  output logic       passed
);

  logic        dir;
  logic [16:0] ny;
  logic [16:0] x_fwd;

  assign ny     = {1'b0, y} + 17'(dy);
  assign passed = (ny >= 17'(V_ACTIVE));
  assign x_fwd  = {1'b0, x} + 17'(STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x   <= 16'(X_INIT);
      y   <= 16'(Y_INIT);
      dir <= DIR_INIT;
    end else if (reload) begin
      x   <= 16'(X_INIT);
      y   <= 16'(Y_INIT);
      dir <= DIR_INIT;
    end else if (advance) begin
      // Wrap keeps the overshoot so spacing between cars is preserved.
      y <= passed ? 16'(ny - 17'(V_ACTIVE)) : ny[15:0];
      if (dir) begin
        if (x_fwd >= 17'(XMAX)) begin
          x   <= 16'(XMAX);
          dir <= 1'b0;
        end else begin
          x <= x_fwd[15:0];
        end
      end else begin
        if (x <= 16'(XMIN + STEP)) begin
          x   <= 16'(XMIN);
          dir <= 1'b1;
        end else begin
          x <= x - 16'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/racing_traffic_ctrl.sv
// Frame-rate game logic: player steering, N_ENEMY enemy lanes, score, lives and crash FSM.
// All outputs registered; state changes land one cycle after frame_tick; no backpressure.
module racing_traffic_ctrl
  import racing_pkg::*;
#(
  parameter int N_ENEMY      = DEF_N_ENEMY,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int TRACK_LEFT   = DEF_TRACK_LEFT,
  parameter int TRACK_RIGHT  = DEF_TRACK_RIGHT,
  parameter int CAR_W        = DEF_CAR_W,
  parameter int STEP         = DEF_STEP,
  parameter int SPEED_INIT   = DEF_SPEED_INIT,
  parameter int SPEED_CRASH  = DEF_SPEED_CRASH,
  parameter int SPEED_MAX    = DEF_SPEED_MAX,
  parameter int LIVES        = DEF_LIVES,
  parameter int CRASH_FRAMES = DEF_CRASH_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  start,
  input  logic                  left,
  input  logic                  right,
  input  logic [N_ENEMY-1:0]    hit_enemy,
  input  logic                  hit_track,
  output logic                  frame_tick,
  output logic [15:0]           player_x,
  output logic [16*N_ENEMY-1:0] enemy_x,
  output logic [16*N_ENEMY-1:0] enemy_y,
  output logic [7:0]            speed,
  output logic [15:0]           track_pos,
  output logic [15:0]           score,
  output logic [3:0]            lives,
  output logic [1:0]            state
);

  localparam int XMIN   = xmin_of(TRACK_LEFT);
  localparam int XMAX   = xmax_of(TRACK_RIGHT, CAR_W);
  localparam int PMAX   = H_ACTIVE - CAR_W;
  localparam int P_INIT = PMAX / 2;
  localparam int CW     = $clog2(CRASH_FRAMES + 1);

  state_t          st;
  logic            vsync_q;
  logic            coll;
  logic [CW-1:0]   crash_cnt;
  logic [N_ENEMY-1:0] passed;
  logic [3:0]      pass_cnt;
  logic [16:0]     score_sum;
  logic [16:0]     px_fwd;
  logic [3:0]      dy;
  logic            advance;
  logic            reload;
  logic            hit_any;

  assign state     = st;
  assign dy        = speed[7:4];
  assign hit_any   = (|hit_enemy) | hit_track;
  assign advance   = frame_tick && (st == S_PLAY) && !coll;
  assign reload    = (st == S_OVER) && start;
  assign px_fwd    = {1'b0, player_x} + 17'(STEP);
  assign score_sum = {1'b0, score} + 17'(pass_cnt);

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < N_ENEMY; i++) pass_cnt = pass_cnt + 4'(passed[i]);
  end

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_lane
    enemy_lane #(
      .X_INIT  (enemy_x0(i, N_ENEMY, XMIN, XMAX)),
      .Y_INIT  (enemy_y0(i, N_ENEMY, V_ACTIVE)),
      .DIR_INIT(1'(i % 2)),
      .XMIN    (XMIN),
      .XMAX    (XMAX),
      .V_ACTIVE(V_ACTIVE),
      .STEP    (STEP)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .reload (reload),
      .advance(advance),
      .dy     (dy),
      .x      (enemy_x[16*i +: 16]),
      .y      (enemy_y[16*i +: 16]),
      .passed (passed[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
      coll       <= 1'b0;
      st         <= S_IDLE;
      player_x   <= 16'(P_INIT);
      speed      <= 8'(SPEED_INIT);
      track_pos  <= '0;
      score      <= '0;
      lives      <= 4'(LIVES);
      crash_cnt  <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync_q & ~vsync;
      // A hit on the tick cycle itself belongs to the next frame: set beats clear.
      if (st == S_PLAY && hit_any) coll <= 1'b1;
      else if (frame_tick)         coll <= 1'b0;

      case (st)
        S_IDLE: if (start) st <= S_PLAY;
        S_PLAY: if (frame_tick) begin
          if (coll) begin
            lives     <= lives - 4'd1;
            speed     <= 8'(SPEED_CRASH);
            crash_cnt <= CW'(CRASH_FRAMES);
            st        <= (lives == 4'd1) ? S_OVER : S_CRASH;
          end else begin
            if (speed < 8'(SPEED_MAX)) speed <= speed + 8'd1;
            track_pos <= track_pos + 16'(dy);
            score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (left && !right)
              player_x <= (player_x >= 16'(STEP)) ? player_x - 16'(STEP) : '0;
            else if (right && !left)
              player_x <= (px_fwd >= 17'(PMAX)) ? 16'(PMAX) : px_fwd[15:0];
          end
        end
        S_CRASH: if (frame_tick) begin
          track_pos <= track_pos + 16'(dy);
          crash_cnt <= crash_cnt - CW'(1);
          if (crash_cnt == CW'(1)) st <= S_PLAY;
        end
        S_OVER: if (start) begin
          st        <= S_PLAY;
          coll      <= 1'b0;
          player_x  <= 16'(P_INIT);
          speed     <= 8'(SPEED_INIT);
          track_pos <= '0;
          score     <= '0;
          lives     <= 4'(LIVES);
          crash_cnt <= '0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
